// File: rtl/ascon_perm_iter_if.sv
// Ascon state type and the request/response bundle between the mode FSM and
// the iterative permutation.
package ascon_pack;
    typedef logic [4:0][63:0] type_state;  // word 0 is x0
endpackage

interface ascon_perm_iter_if;
    logic                  start_i;
    logic [3:0]            rounds_i;
    ascon_pack::type_state state_i;
    ascon_pack::type_state state_o;
    logic                  busy_o;
    logic                  done_o;
    logic [3:0]            round_o;

    modport master (
        output start_i, rounds_i, state_i,
        input  state_o, busy_o, done_o, round_o
    );

    modport slave (
        input  start_i, rounds_i, state_i,
        output state_o, busy_o, done_o, round_o
    );
endinterface

// File: rtl/ascon_perm_iter.sv
// Iterative Ascon permutation p^n, one round per clock. The start cycle feeds
// the round datapath from state_i, every later cycle from the round register.
module ascon_perm_iter (
    input  logic              clock_i,
    input  logic              reset_i,
    ascon_perm_iter_if.slave  bus
);
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    function automatic logic [63:0] ror(input logic [63:0] x, input int unsigned k);
        return (x >> k) | (x << (64 - k));
    endfunction

    function automatic logic [4:0][63:0] ascon_round(input logic [4:0][63:0] s,
                                                     input logic [3:0]       r);
        logic [63:0] x0, x1, x2, x3, x4;
        logic [63:0] t0, t1, t2, t3, t4;
        x0 = s[0]; x1 = s[1]; x2 = s[2]; x3 = s[3]; x4 = s[4];
        x2 = x2 ^ {56'h0, 8'hF0 - ({4'h0, r} * 8'h0F)};
        x0 = x0 ^ x4; x4 = x4 ^ x3; x2 = x2 ^ x1;
        t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
        x0 = x0 ^ t1; x1 = x1 ^ t2; x2 = x2 ^ t3; x3 = x3 ^ t4; x4 = x4 ^ t0;
        x1 = x1 ^ x0; x0 = x0 ^ x4; x3 = x3 ^ x2; x2 = ~x2;
        x0 = x0 ^ ror(x0, 19) ^ ror(x0, 28);
        x1 = x1 ^ ror(x1, 61) ^ ror(x1, 39);
        x2 = x2 ^ ror(x2, 1)  ^ ror(x2, 6);
        x3 = x3 ^ ror(x3, 10) ^ ror(x3, 17);
        x4 = x4 ^ ror(x4, 7)  ^ ror(x4, 41);
        return {x4, x3, x2, x1, x0};
    endfunction

    logic [0:0]       fsm_q, fsm_d;
    logic [4:0][63:0] state_q, state_d;
    logic [3:0]       round_q, round_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             sel_start;
    logic [3:0]       n_eff;
    logic [3:0]       rnd_idx;
    logic [4:0][63:0] rnd_in;
    logic [4:0][63:0] rnd_out;

    // Out-of-range round counts fall back to the full p^12.
    assign n_eff     = (bus.rounds_i == 4'd0 || bus.rounds_i > 4'd12) ? 4'd12 : bus.rounds_i;
    assign sel_start = (fsm_q == S_IDLE) && bus.start_i;
    assign rnd_idx   = sel_start ? (4'd12 - n_eff) : (round_q + 4'd1);
    assign rnd_in    = sel_start ? bus.state_i : state_q;
    assign rnd_out   = ascon_round(rnd_in, rnd_idx);

    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        round_d = round_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (fsm_q)
            S_IDLE: begin
                // The done cycle is already IDLE, so busy drops here unless restarted.
                busy_d = 1'b0;
                if (bus.start_i) begin
                    state_d = rnd_out;
                    round_d = rnd_idx;
                    busy_d  = 1'b1;
                    if (rnd_idx == 4'd11) done_d = 1'b1;
                    else                  fsm_d  = S_RUN;
                end
            end
            S_RUN: begin
                state_d = rnd_out;
                round_d = rnd_idx;
                if (rnd_idx == 4'd11) begin
                    fsm_d  = S_IDLE;
                    done_d = 1'b1;
                end
            end
            default: fsm_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            fsm_q   <= S_IDLE;
            state_q <= '0;
            round_q <= 4'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            round_q <= round_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.state_o = state_q;
    assign bus.round_o = round_q;
    assign bus.busy_o  = busy_q;
    assign bus.done_o  = done_q;
endmodule

// File: tb/tb_ascon_perm_iter.sv
// Scoreboarded bench for ascon_perm_iter: table-driven column S-box model,
// expected results queued at start, compared on done_o.
module tb_ascon_perm_iter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ascon_perm_iter_if bus();
    ascon_perm_iter dut (.clock_i(clk), .reset_i(rst), .bus(bus));

    int n_checks = 0;
    int n_fail   = 0;
    logic [319:0] sb_q[$];

    logic [7:0] RC [12] = '{8'hF0, 8'hE1, 8'hD2, 8'hC3, 8'hB4, 8'hA5,
                            8'h96, 8'h87, 8'h78, 8'h69, 8'h5A, 8'h4B};
    logic [4:0] SBOX [32] = '{5'h04, 5'h0B, 5'h1F, 5'h14, 5'h1A, 5'h15, 5'h09, 5'h02,
                              5'h1B, 5'h05, 5'h08, 5'h12, 5'h1D, 5'h03, 5'h06, 5'h1C,
                              5'h1E, 5'h13, 5'h07, 5'h0E, 5'h00, 5'h0D, 5'h11, 5'h18,
                              5'h10, 5'h0C, 5'h01, 5'h19, 5'h16, 5'h0A, 5'h0F, 5'h17};

    task automatic chk(input string tag, input logic [319:0] act, input logic [319:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, act, exp);
        end
    endtask

    function automatic logic [63:0] rotr(input logic [63:0] x, input int k);
        logic [127:0] d;
        d = {x, x} >> k;
        return d[63:0];
    endfunction

    function automatic int eff_n(input logic [3:0] rf);
        return (rf == 4'd0 || rf > 4'd12) ? 12 : int'(rf);
    endfunction

    function automatic logic [319:0] model_perm(input logic [319:0] s, input int n);
        logic [63:0] x [5];
        logic [4:0]  v;
        for (int i = 0; i < 5; i++) x[i] = s[64*i +: 64];
        for (int r = 12 - n; r < 12; r++) begin
            x[2][7:0] = x[2][7:0] ^ RC[r];
            for (int b = 0; b < 64; b++) begin
                v = SBOX[{x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]}];
                {x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]} = v;
            end
            x[0] = x[0] ^ rotr(x[0], 19) ^ rotr(x[0], 28);
            x[1] = x[1] ^ rotr(x[1], 61) ^ rotr(x[1], 39);
            x[2] = x[2] ^ rotr(x[2], 1)  ^ rotr(x[2], 6);
            x[3] = x[3] ^ rotr(x[3], 10) ^ rotr(x[3], 17);
            x[4] = x[4] ^ rotr(x[4], 7)  ^ rotr(x[4], 41);
        end
        return {x[4], x[3], x[2], x[1], x[0]};
    endfunction

    function automatic logic [319:0] rand_state();
        logic [319:0] s;
        for (int i = 0; i < 10; i++) s[32*i +: 32] = $urandom;
        return s;
    endfunction

    // Scoreboard side: every done pulse must match the oldest queued result.
    always @(negedge clk) begin
        if (!rst && bus.done_o) begin
            if (sb_q.size() == 0) chk("unexpected_done", 1, 0);
            else                  chk("sb_state", bus.state_o, sb_q.pop_front());
        end
    end

    // Called just after a negedge; returns just after the start edge E0.
    task automatic start_perm(input logic [319:0] st, input logic [3:0] rf, input bit push);
        bus.start_i  = 1'b1;
        bus.rounds_i = rf;
        bus.state_i  = st;
        if (push) sb_q.push_back(model_perm(st, eff_n(rf)));
        @(posedge clk);
        #1;
        bus.start_i  = 1'b0;
        bus.rounds_i = 4'($urandom_range(0, 15));
        bus.state_i  = rand_state();
    endtask

    task automatic run_check(input logic [319:0] st, input logic [3:0] rf, input bit poke);
        int n;
        n = eff_n(rf);
        start_perm(st, rf, 1'b1);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            chk("round_idx", bus.round_o, 320'(12 - n + k));
            chk("busy_run", bus.busy_o, 1);
            chk("done_pos", bus.done_o, (k == n - 1) ? 1 : 0);
            if (poke && k == 1 && n > 3) begin
                bus.start_i  = 1'b1;
                bus.rounds_i = 4'd1;
                bus.state_i  = rand_state();
            end else begin
                bus.start_i  = 1'b0;
            end
        end
        @(negedge clk);
        chk("busy_after", bus.busy_o, 0);
        chk("done_after", bus.done_o, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        bus.start_i  = 1'b0;
        bus.rounds_i = 4'd0;
        bus.state_i  = '0;

        // Reset held with start asserted must not launch anything.
        rst = 1'b1;
        bus.start_i  = 1'b1;
        bus.rounds_i = 4'd12;
        bus.state_i  = rand_state();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        bus.start_i = 1'b0;
        @(negedge clk);
        chk("rst_state", bus.state_o, 0);
        chk("rst_busy", bus.busy_o, 0);
        chk("rst_done", bus.done_o, 0);
        chk("rst_round", bus.round_o, 0);
        @(negedge clk);
        chk("rst_nostart", bus.busy_o, 0);

        // Single round on an all-zero state against the known vector.
        start_perm('0, 4'd1, 1'b1);
        @(negedge clk);
        chk("p1_x0", bus.state_o[0], 64'h000964B00000004B);
        chk("p1_x1", bus.state_o[1], 64'h0000000096000213);
        chk("p1_x2", bus.state_o[2], 64'h53FFFFFFFFFFFF90);
        chk("p1_x3", bus.state_o[3], 64'h12E580000000004B);
        chk("p1_x4", bus.state_o[4], 64'h0);
        chk("p1_done", bus.done_o, 1);
        chk("p1_busy", bus.busy_o, 1);
        chk("p1_round", bus.round_o, 11);
        @(negedge clk);
        chk("p1_done_clr", bus.done_o, 0);
        chk("p1_busy_clr", bus.busy_o, 0);

        run_check(rand_state(), 4'd12, 1'b0);
        run_check(rand_state(), 4'd6,  1'b0);
        run_check(rand_state(), 4'd8,  1'b0);
        run_check(rand_state(), 4'd12, 1'b1);
        run_check(rand_state(), 4'd0,  1'b0);
        run_check(rand_state(), 4'd13, 1'b1);

        // start_i held: restart in each done cycle; three p^6 accepted.
        @(negedge clk);
        begin
            logic [319:0] s;
            s = rand_state();
            bus.start_i  = 1'b1;
            bus.rounds_i = 4'd6;
            bus.state_i  = s;
            for (int i = 0; i < 3; i++) sb_q.push_back(model_perm(s, 6));
        end
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            chk("b2b_done", bus.done_o, (c == 5 || c == 11 || c == 17) ? 1 : 0);
            chk("b2b_busy", bus.busy_o, (c < 18) ? 1 : 0);
            if (c == 12) bus.start_i = 1'b0;
        end

        // Reset in the middle of p^12 discards it; a fresh start then completes.
        start_perm(rand_state(), 4'd12, 1'b0);
        seen = 0;
        for (int c = 0; c < 20 && seen == 0; c++) begin
            @(negedge clk);
            if (bus.round_o == 4'd5) seen = 1;
        end
        chk("mid_reach_r5", seen, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_state", bus.state_o, 0);
        chk("mid_rst_busy", bus.busy_o, 0);
        chk("mid_rst_done", bus.done_o, 0);
        chk("mid_rst_round", bus.round_o, 0);
        rst = 1'b0;
        repeat (14) begin
            @(negedge clk);
            chk("mid_no_done", bus.done_o, 0);
        end
        run_check(rand_state(), 4'd12, 1'b0);

        @(negedge clk);
        chk("sb_empty", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
